// File: rtl/pipe_stall_ctrl.sv
// Front-end stall/flush controller: owns PC, IF/ID and the control half of ID/EX,
// applies hazard-unit write enables, branch flush, stall counting and a stall watchdog.
module pipe_stall_ctrl #(
    parameter int                 PC_W      = 8,
    parameter int                 INSTR_W   = 16,
    parameter int                 CTRL_W    = 8,
    parameter int                 PC_INC    = 1,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP       = '0,
    parameter int                 CNT_W     = 16,
    parameter int                 MAX_STALL = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               st,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic               ex_valid,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               stall_err
);
    localparam int RL_W = $clog2(MAX_STALL + 2);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL + 1);

    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [PC_W-1:0]    ifid_pc_reg, ifid_pc_next;
    logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
    logic               ifid_valid_reg, ifid_valid_next;
    logic [CTRL_W-1:0]  ex_ctrl_reg, ex_ctrl_next;
    logic               ex_valid_reg, ex_valid_next;
    logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
    logic [RL_W-1:0]    run_reg, run_next;
    logic               stall_err_reg, stall_err_next;
    logic               br_eff;

    // A branch seen during a stall is ignored; ID re-presents it once unstalled.
    assign br_eff = br_taken & ~st;

    always_comb begin
        pc_next         = pc_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        ex_ctrl_next    = id_ctrl;
        ex_valid_next   = ifid_valid_reg;
        stall_cnt_next  = stall_cnt_reg;
        run_next        = '0;

        if (pc_write) begin
            if (br_eff) pc_next = br_target;
            else        pc_next = pc_reg + PC_W'(PC_INC);
        end

        if (ifid_write) begin
            ifid_pc_next = pc_reg;
            if (br_eff) begin
                ifid_instr_next = NOP;
                ifid_valid_next = 1'b0;
            end else begin
                ifid_instr_next = imem_instr;
                ifid_valid_next = 1'b1;
            end
        end

        if (st) begin
            ex_ctrl_next  = '0;
            ex_valid_next = 1'b0;
            if (stall_cnt_reg != {CNT_W{1'b1}}) stall_cnt_next = stall_cnt_reg + 1'b1;
            run_next = (run_reg == RL_MAX) ? RL_MAX : run_reg + 1'b1;
        end

        stall_err_next = stall_err_reg | (run_next == RL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= NOP;
            ifid_valid_reg <= 1'b0;
            ex_ctrl_reg    <= '0;
            ex_valid_reg   <= 1'b0;
            stall_cnt_reg  <= '0;
            run_reg        <= '0;
            stall_err_reg  <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            ex_ctrl_reg    <= ex_ctrl_next;
            ex_valid_reg   <= ex_valid_next;
            stall_cnt_reg  <= stall_cnt_next;
            run_reg        <= run_next;
            stall_err_reg  <= stall_err_next;
        end
    end

    assign pc         = pc_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;
    assign ifid_valid = ifid_valid_reg;
    assign ex_ctrl    = ex_ctrl_reg;
    assign ex_valid   = ex_valid_reg;
    assign stall_cnt  = stall_cnt_reg;
    assign stall_err  = stall_err_reg;
endmodule
